// File: rtl/sw_step_decoder_if.sv
// Bundles the state-register tap (sample strobe + Q) and the decoded
// command / lock outputs of sw_step_decoder.
interface sw_step_decoder_if #(
    parameter int unsigned CNT_W = 4
);
    logic             q_valid;
    logic [1:0]       q;
    logic [1:0]       sw_dec;
    logic             sw_dec_valid;
    logic [CNT_W-1:0] run_len;
    logic [1:0]       sw_lock;
    logic             locked;
    logic             lock_change;

    // Source side: drives the Q samples, observes the decoded results.
    modport master (
        output q_valid, q,
        input  sw_dec, sw_dec_valid, run_len, sw_lock, locked, lock_change
    );

    // Decoder side.
    modport slave (
        input  q_valid, q,
        output sw_dec, sw_dec_valid, run_len, sw_lock, locked, lock_change
    );
endinterface

// File: rtl/sw_step_decoder.sv
// Recovers the switch command behind each step of the 2-bit state register
// (delta of consecutive Q samples) and locks onto a command once it has been
// decoded CONFIRM_N times in a row. Purely observational.
module sw_step_decoder #(
    parameter int unsigned CONFIRM_N = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    sw_step_decoder_if.slave    bus
);
    typedef enum logic {
        S_EMPTY,
        S_TRACK
    } state_t;

    localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM_N);

    state_t           r_state;
    logic [1:0]       r_prev;
    logic [1:0]       r_sw_dec;
    logic             r_sw_dec_valid;
    logic [CNT_W-1:0] r_run_len;
    logic [1:0]       r_sw_lock;
    logic             r_locked;
    logic             r_lock_change;

    logic [1:0]       w_delta;
    logic [1:0]       w_map;
    logic [CNT_W-1:0] w_run_next;
    logic             w_lock_fire;

    // Step delta to command map, next run length and lock decision.
    always_comb begin
        w_delta = bus.q - r_prev;
        w_map   = 2'b00;
        case (w_delta)
            2'd1:    w_map = 2'b00;
            2'd3:    w_map = 2'b01;
            2'd0:    w_map = 2'b10;
            default: w_map = 2'b11;
        endcase
        if (w_map == r_sw_dec && r_run_len != '0) begin
            w_run_next = (r_run_len == '1) ? r_run_len : r_run_len + 1'b1;
        end else begin
            w_run_next = CNT_W'(1);
        end
        w_lock_fire = (w_run_next == CONFIRM_C) && (!r_locked || r_sw_lock != w_map);
    end

    // Priming/tracking FSM with all outputs registered; rst and clr are equivalent.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state        <= S_EMPTY;
            r_prev         <= '0;
            r_sw_dec       <= '0;
            r_sw_dec_valid <= 1'b0;
            r_run_len      <= '0;
            r_sw_lock      <= '0;
            r_locked       <= 1'b0;
            r_lock_change  <= 1'b0;
        end else begin
            r_sw_dec_valid <= 1'b0;
            r_lock_change  <= 1'b0;
            if (bus.q_valid) begin
                r_prev <= bus.q;
                case (r_state)
                    S_EMPTY: begin
                        r_state <= S_TRACK;
                    end
                    default: begin
                        r_sw_dec       <= w_map;
                        r_sw_dec_valid <= 1'b1;
                        r_run_len      <= w_run_next;
                        if (w_lock_fire) begin
                            r_sw_lock     <= w_map;
                            r_locked      <= 1'b1;
                            r_lock_change <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.sw_dec       = r_sw_dec;
    assign bus.sw_dec_valid = r_sw_dec_valid;
    assign bus.run_len      = r_run_len;
    assign bus.sw_lock      = r_sw_lock;
    assign bus.locked       = r_locked;
    assign bus.lock_change  = r_lock_change;
endmodule

// File: doc/sw_step_decoder.md
Name: sw_step_decoder

Overview:
- Inverse of the 4-state switch-controlled next-state logic: watches the 2-bit state register stream and recovers which switch command produced each step.
- Confirms the command once it holds steadily, for display on LEDs or 7-segment.
- Sits beside the state register and taps Q and a sample strobe; it has no influence on the state machine.

Parameters:
- CONFIRM_N, 3, number of consecutive identical decoded commands needed to lock (legal range 1..2^CNT_W-1).
- CNT_W, 4, width of the run-length counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous clear; same effect as rst on all state and outputs.
- q_valid  input  1  Q sample strobe; q is taken only when high.
- q  input  2  current state register value.
- sw_dec  output  2  command decoded from the latest step.
- sw_dec_valid  output  1  one-cycle pulse; sw_dec is updated this cycle.
- run_len  output  CNT_W  consecutive count of the current sw_dec value, saturating.
- sw_lock  output  2  confirmed command.
- locked  output  1  sw_lock holds a confirmed command.
- lock_change  output  1  one-cycle pulse when sw_lock is loaded (first lock or a new command).

Behaviour:
- All registers are clocked on the rising edge of clk. rst and clr are synchronous, active-high and have identical effect.
- Reset values: sw_dec=0, sw_dec_valid=0, run_len=0, sw_lock=0, locked=0, lock_change=0, prev=0, state=EMPTY.
- FSM state EMPTY (no previous sample held):
  - q_valid=1: prev<=q, go to TRACK.
  - No decode, no pulses.
- FSM state TRACK, q_valid=1:
  - delta=(q-prev) mod 4, computed in 2 bits so wrap is natural.
  - Map: delta 1 -> 00; delta 3 -> 01; delta 0 -> 10; delta 2 -> 11. The map is total, so there is no error case.
  - prev<=q.
  - sw_dec<=mapped value; sw_dec_valid=1 in the following cycle. Latency is 1 clock from the sampling edge.
- run_len on each decode:
  - Mapped value equals the current sw_dec and run_len>0: run_len+1, saturating at 2^CNT_W-1.
  - Otherwise: run_len=1.
- Lock, evaluated with the new run_len in the same update:
  - Condition: new run_len==CONFIRM_N and (locked==0 or sw_lock!=mapped value).
  - Action: sw_lock<=mapped value, locked<=1, lock_change=1 for one cycle.
  - The lock fires only on the exact CONFIRM_N crossing, never again while saturated.
  - locked never returns to 0 except on rst or clr. Unconfirmed different commands leave sw_lock unchanged.
- q_valid=0: all registers hold; sw_dec_valid=0 and lock_change=0. Gaps of any length do not break a run.
- Pulses sw_dec_valid and lock_change are high for exactly one cycle per event and can coincide.
- rst or clr asserted together with q_valid: reset wins and the sample is discarded. The next valid sample only primes prev.
- Reset mid-run: run_len clears. Lock requires CONFIRM_N fresh decodes after re-priming, i.e. CONFIRM_N+1 valid samples.
- CONFIRM_N=1: every change of command produces lock_change on its first decode.

Test Plan:
- rst, then q=0,1,2,3,0 with q_valid=1 each cycle:
  - 4 sw_dec_valid pulses, all sw_dec=00; run_len=1,2,3,4.
  - lock_change on the 3rd decode; sw_lock=00, locked=1.
- Wrap/+2: q=3,1,3,1 -> sw_dec=11 ×3; deltas 2 across the 3->1 wrap; lock to 11 on the 3rd decode.
- Command change while locked on 00:
  - Feed q=1,0,3,2.
  - sw_dec=01 ×3; run_len resets to 1 on the first 01.
  - lock_change at the 3rd 01; sw_lock=01.
  - A single interleaved 10 step instead keeps sw_lock=00 with no pulse.
- Hold and gaps: q=2 held with q_valid toggling 1,0,0,1,0,1,1:
  - sw_dec=10 pulses only on valid cycles.
  - run counts 1,2,3 across the gaps; lock to 10.
  - Then 15+ more holds: run_len saturates at 15 with no further lock_change.
- Reset mid-operation: locked on 00 at run_len=2, rst pulse concurrent with q_valid=1:
  - All outputs are 0 next cycle.
  - The next sample gives no pulse.
  - Lock reappears only after 3 further decodes.
- clr behaves identically to rst: repeat the previous scenario with clr and compare outputs cycle-for-cycle.
